// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: control FSM for a multicycle MIPS datapath (shared ALU, unified memory port).
// Optional MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall until mem_ready.
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_size,
  output logic       mem_unsigned,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic [3:0] alu_ctrl,
  output logic [3:0] state,
  output logic       illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB,
    BRANCH, IEXEC, IWB, JUMP, JREG
  } state_t;
  state_t st;
  logic rdy;
`ifdef MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif
  logic is_load, is_store, is_r, is_jr, is_br, is_imm, is_j, is_ext, r_ok, legal, cond;
  logic [3:0] r_code, i_code;
  assign is_load  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign is_store = op inside {6'h28, 6'h29, 6'h2b};
  assign is_r     = op == 6'h00;
  assign is_jr    = funct == 6'h08;
  assign is_br    = op[5:2] == 4'b0001;
  assign is_imm   = op[5:3] == 3'b001;
  assign is_j     = op == 6'h02;
  assign is_ext   = op inside {6'h0c, 6'h0d, 6'h0e};
  assign legal    = is_load | is_store | (is_r & (is_jr | r_ok)) | is_br | is_imm | is_j;
  assign cond     = op[1] ? (op[0] ? (!zero & !neg) : (zero | neg)) : (op[0] ? !zero : zero);
  always_comb begin
    r_ok = 1'b1;
    r_code = 4'd0;
    case (funct)
      6'h00, 6'h04: r_code = 4'd8;
      6'h02, 6'h06: r_code = 4'd9;
      6'h03, 6'h07: r_code = 4'd10;
      6'h20, 6'h21: r_code = 4'd0;
      6'h22, 6'h23: r_code = 4'd1;
      6'h24:        r_code = 4'd2;
      6'h25:        r_code = 4'd3;
      6'h26:        r_code = 4'd4;
      6'h27:        r_code = 4'd5;
      6'h2a:        r_code = 4'd6;
      6'h2b:        r_code = 4'd7;
      default:      r_ok = 1'b0;
    endcase
  end
  always_comb begin
    case (op[2:0])
      3'd2:    i_code = 4'd6;
      3'd3:    i_code = 4'd7;
      3'd4:    i_code = 4'd2;
      3'd5:    i_code = 4'd3;
      3'd6:    i_code = 4'd4;
      3'd7:    i_code = 4'd11;
      default: i_code = 4'd0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) st <= FETCH;
    else case (st)
      FETCH:   st <= rdy ? DECODE : FETCH;
      DECODE:  st <= (is_load | is_store) ? MEMADR :
                     is_r ? (is_jr ? JREG : r_ok ? EXEC : FETCH) :
                     is_br ? BRANCH : is_imm ? IEXEC : is_j ? JUMP : FETCH;
      MEMADR:  st <= is_load ? MEMRD : MEMWR;
      MEMRD:   st <= rdy ? MEMWB : MEMRD;
      MEMWR:   st <= rdy ? FETCH : MEMWR;
      EXEC:    st <= ALUWB;
      IEXEC:   st <= IWB;
      default: st <= FETCH;
    endcase
  end
  assign state = st;
  always_comb begin
    pc_en = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    ext_zero = 1'b0;
    pc_src = 2'b00;
    alu_ctrl = 4'd0;
    illegal = 1'b0;
    case (st)
      FETCH:   begin mem_read = 1'b1; ir_write = rdy; pc_en = rdy; alu_src_b = 2'b01; end
      DECODE:  begin alu_src_b = 2'b11; illegal = !legal; end
      MEMADR:  begin alu_src_a = 2'b01; alu_src_b = 2'b10; end
      MEMRD:   begin iord = 1'b1; mem_read = 1'b1; end
      MEMWB:   begin mem_to_reg = 1'b1; reg_write = 1'b1; end
      MEMWR:   begin iord = 1'b1; mem_write = 1'b1; end
      EXEC:    begin alu_src_a = (funct[5:2] == 4'd0) ? 2'b10 : 2'b01; alu_ctrl = r_code; end
      ALUWB:   begin reg_dst = 1'b1; reg_write = 1'b1; end
      BRANCH:  begin alu_src_a = 2'b01; alu_ctrl = 4'd1; pc_src = 2'b01; pc_en = cond; end
      IEXEC:   begin alu_src_a = 2'b01; alu_src_b = 2'b10; ext_zero = is_ext; alu_ctrl = i_code; end
      IWB:     begin reg_write = 1'b1; ext_zero = is_ext; end
      JUMP:    begin pc_src = 2'b10; pc_en = 1'b1; end
      JREG:    begin pc_src = 2'b11; pc_en = 1'b1; end
      default: ;
    endcase
    mem_size = (st inside {MEMRD, MEMWB, MEMWR}) ? ((op[1:0] == 2'b11) ? 2'b10 : op[1:0]) : 2'b00;
    mem_unsigned = (st inside {MEMRD, MEMWB, MEMWR}) & op[2];
    if (rst) begin
      pc_en = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      illegal = 1'b0;
    end
  end
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed-vector bench for the multicycle control FSM.
module tb_mips_mc_ctrl;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, neg = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = 6'h00, funct = 6'h20;
  logic pc_en, iord, mem_read, mem_write, mem_unsigned, ir_write, reg_dst, mem_to_reg, reg_write, ext_zero, illegal;
  logic [1:0] mem_size, alu_src_a, alu_src_b, pc_src;
  logic [3:0] alu_ctrl, state;
  logic [8:0] en;
  int n_chk = 0, n_fail = 0;
  assign en = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal};
  always #5 clk = ~clk;
  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .pc_src(pc_src), .alu_ctrl(alu_ctrl), .state(state), .illegal(illegal)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    tick;
    n_chk++; if (en !== 9'd0) begin n_fail++; $display("FAIL reset_en got=%b exp=%b", en, 9'd0); end
    tick;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_chk++; if (en !== 9'd0) begin n_fail++; $display("FAIL reset_en2 got=%b exp=%b", en, 9'd0); end
    rst = 1'b0;
    #1;
    n_chk++; if (en !== 9'b101010000) begin n_fail++; $display("FAIL fetch_en got=%b exp=%b", en, 9'b101010000); end
    n_chk++; if ({alu_src_a, alu_src_b, pc_src, alu_ctrl} !== 10'b00_01_00_0000) begin n_fail++; $display("FAIL fetch_mux got=%b", {alu_src_a, alu_src_b, pc_src, alu_ctrl}); end
  endtask
  task automatic test_rtype(input logic [5:0] f, input logic [3:0] ea, input logic [1:0] sa);
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    op = 6'h00; funct = f; #1;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (state !== es[i]) begin n_fail++; $display("FAIL rtype_state f=%h i=%0d got=%0d exp=%0d", f, i, state, es[i]); end
      if (i == 1) begin
        n_chk++; if (alu_src_b !== 2'b11) begin n_fail++; $display("FAIL decode_srcb got=%b exp=11", alu_src_b); end
      end
      if (i == 2) begin
        n_chk++; if ({alu_ctrl, alu_src_a, alu_src_b} !== {ea, sa, 2'b00}) begin n_fail++; $display("FAIL exec f=%h got=%b exp=%b", f, {alu_ctrl, alu_src_a, alu_src_b}, {ea, sa, 2'b00}); end
      end
      if (i == 3) begin
        n_chk++; if (en !== 9'b000001010) begin n_fail++; $display("FAIL aluwb_en got=%b exp=%b", en, 9'b000001010); end
      end
      if (i < 4) tick;
    end
  endtask
  task automatic test_load(input logic [5:0] o, input logic [1:0] sz, input logic un);
    logic [3:0] es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    op = o; #1;
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (state !== es[i]) begin n_fail++; $display("FAIL load_state op=%h i=%0d got=%0d exp=%0d", o, i, state, es[i]); end
      n_chk++; if (reg_write !== (i == 4)) begin n_fail++; $display("FAIL load_regwrite i=%0d got=%b", i, reg_write); end
      if (i == 2) begin
        n_chk++; if ({alu_src_a, alu_src_b, alu_ctrl} !== 8'b01_10_0000) begin n_fail++; $display("FAIL memadr got=%b", {alu_src_a, alu_src_b, alu_ctrl}); end
      end
      if (i == 3) begin
        n_chk++; if ({en, mem_size, mem_unsigned} !== {9'b011000000, sz, un}) begin n_fail++; $display("FAIL memrd op=%h got=%b exp=%b", o, {en, mem_size, mem_unsigned}, {9'b011000000, sz, un}); end
      end
      if (i == 4) begin
        n_chk++; if ({en, mem_size, mem_unsigned} !== {9'b000000110, sz, un}) begin n_fail++; $display("FAIL memwb op=%h got=%b exp=%b", o, {en, mem_size, mem_unsigned}, {9'b000000110, sz, un}); end
      end
      if (i < 5) tick;
    end
  endtask
  task automatic test_store(input logic [5:0] o, input logic [1:0] sz);
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    op = o; #1;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (state !== es[i]) begin n_fail++; $display("FAIL store_state op=%h i=%0d got=%0d exp=%0d", o, i, state, es[i]); end
      if (i == 3) begin
        n_chk++; if ({en, mem_size} !== {9'b010100000, sz}) begin n_fail++; $display("FAIL memwr op=%h got=%b exp=%b", o, {en, mem_size}, {9'b010100000, sz}); end
      end
      if (i < 4) tick;
    end
  endtask
  task automatic test_branch(input logic [5:0] o, input logic z, input logic n, input logic ep);
    op = o; zero = z; neg = n; #1;
    tick; tick;
    n_chk++; if (state !== 4'd8) begin n_fail++; $display("FAIL branch_state op=%h got=%0d exp=8", o, state); end
    n_chk++; if ({pc_en, pc_src, alu_ctrl, alu_src_a, alu_src_b} !== {ep, 2'b01, 4'd1, 2'b01, 2'b00}) begin n_fail++; $display("FAIL branch op=%h z=%b n=%b got=%b exp=%b", o, z, n, {pc_en, pc_src, alu_ctrl, alu_src_a, alu_src_b}, {ep, 2'b01, 4'd1, 2'b01, 2'b00}); end
    tick;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL branch_ret got=%0d exp=0", state); end
    zero = 1'b0; neg = 1'b0;
  endtask
  task automatic test_imm(input logic [5:0] o, input logic [3:0] ea, input logic ez);
    op = o; #1;
    tick; tick;
    n_chk++; if ({state, alu_ctrl, ext_zero, alu_src_a, alu_src_b} !== {4'd9, ea, ez, 2'b01, 2'b10}) begin n_fail++; $display("FAIL iexec op=%h got=%b exp=%b", o, {state, alu_ctrl, ext_zero, alu_src_a, alu_src_b}, {4'd9, ea, ez, 2'b01, 2'b10}); end
    tick;
    n_chk++; if ({state, en, ext_zero} !== {4'd10, 9'b000000010, ez}) begin n_fail++; $display("FAIL iwb op=%h got=%b exp=%b", o, {state, en, ext_zero}, {4'd10, 9'b000000010, ez}); end
    tick;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL imm_ret got=%0d exp=0", state); end
  endtask
  task automatic test_jump(input logic [5:0] o, input logic [5:0] f, input logic [3:0] es, input logic [1:0] ps);
    op = o; funct = f; #1;
    tick; tick;
    n_chk++; if ({state, pc_en, pc_src} !== {es, 1'b1, ps}) begin n_fail++; $display("FAIL jump op=%h f=%h got=%b exp=%b", o, f, {state, pc_en, pc_src}, {es, 1'b1, ps}); end
    tick;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL jump_ret got=%0d exp=0", state); end
  endtask
  task automatic test_illegal(input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f; #1;
    n_chk++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_fetch got=%b exp=0", illegal); end
    tick;
    n_chk++; if ({state, en} !== {4'd1, 9'b000000001}) begin n_fail++; $display("FAIL illegal_decode op=%h f=%h got=%b exp=%b", o, f, {state, en}, {4'd1, 9'b000000001}); end
    tick;
    n_chk++; if ({state, illegal, reg_write, mem_write} !== {4'd0, 3'b000}) begin n_fail++; $display("FAIL illegal_ret got=%b exp=%b", {state, illegal, reg_write, mem_write}, {4'd0, 3'b000}); end
  endtask
  task automatic test_reset_midflight;
    op = 6'h2b; #1;
    tick; tick; tick;
    n_chk++; if ({state, mem_write} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL mid_pre got=%b exp=%b", {state, mem_write}, {4'd5, 1'b1}); end
    rst = 1'b1; #1;
    n_chk++; if (en !== 9'b010000000) begin n_fail++; $display("FAIL mid_drop got=%b exp=%b", en, 9'b010000000); end
    tick;
    n_chk++; if ({state, en} !== {4'd0, 9'd0}) begin n_fail++; $display("FAIL mid_rst got=%b exp=%b", {state, en}, {4'd0, 9'd0}); end
    rst = 1'b0; #1;
  endtask
  task automatic test_mem_ready;
    op = 6'h2b;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b0; #1;
    n_chk++; if ({state, en} !== {4'd0, 9'b001000000}) begin n_fail++; $display("FAIL fetch_wait got=%b exp=%b", {state, en}, {4'd0, 9'b001000000}); end
    tick;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL fetch_hold got=%0d exp=0", state); end
    mem_ready = 1'b1; #1;
    tick; tick; tick;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      n_chk++; if ({state, mem_write} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL memwr_wait i=%0d got=%b exp=%b", i, {state, mem_write}, {4'd5, 1'b1}); end
      tick;
    end
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL memwr_release got=%0d exp=0", state); end
`else
    mem_ready = 1'b0; #1;
    n_chk++; if ({pc_en, ir_write} !== 2'b11) begin n_fail++; $display("FAIL noready_fetch got=%b exp=11", {pc_en, ir_write}); end
    tick; tick; tick;
    n_chk++; if ({state, mem_write} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL noready_memwr got=%b exp=%b", {state, mem_write}, {4'd5, 1'b1}); end
    tick;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL noready_ret got=%0d exp=0", state); end
`endif
    mem_ready = 1'b1; #1;
  endtask
  initial begin
    test_reset;
    test_rtype(6'h20, 4'd0, 2'b01);
    test_rtype(6'h23, 4'd1, 2'b01);
    test_rtype(6'h03, 4'd10, 2'b10);
    test_rtype(6'h06, 4'd9, 2'b01);
    test_rtype(6'h2a, 4'd6, 2'b01);
    test_load(6'h20, 2'b00, 1'b0);
    test_load(6'h25, 2'b01, 1'b1);
    test_load(6'h23, 2'b10, 1'b0);
    test_store(6'h29, 2'b01);
    test_store(6'h2b, 2'b10);
    test_store(6'h28, 2'b00);
    test_branch(6'h04, 1'b1, 1'b0, 1'b1);
    test_branch(6'h04, 1'b0, 1'b0, 1'b0);
    test_branch(6'h06, 1'b0, 1'b1, 1'b1);
    test_branch(6'h07, 1'b1, 1'b0, 1'b0);
    test_branch(6'h07, 1'b0, 1'b0, 1'b1);
    test_branch(6'h05, 1'b0, 1'b0, 1'b1);
    test_imm(6'h0d, 4'd3, 1'b1);
    test_imm(6'h0f, 4'd11, 1'b0);
    test_imm(6'h0b, 4'd7, 1'b0);
    test_imm(6'h08, 4'd0, 1'b0);
    test_jump(6'h02, 6'h00, 4'd11, 2'b10);
    test_jump(6'h00, 6'h08, 4'd12, 2'b11);
    test_illegal(6'h3f, 6'h20);
    test_illegal(6'h00, 6'h01);
    test_reset_midflight;
    test_mem_ready;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Control FSM that sequences a multicycle MIPS datapath: shared ALU, single unified memory port, IR, A/B/ALUOut/MDR latches.
- Decodes opcode/funct from the IR and drives all mux selects, write enables and the ALU operation code each cycle.
- Sits beside the datapath inside the multicycle top, in the position the decoder occupies in the single-cycle core.

Parameters:
- (none)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- neg  in  1  ALU result[31]
- mem_ready  in  1  memory done (used only with MEM_WAIT_EN)
- pc_en  out  1  PC load = pc_write | (branch & cond)
- iord  out  1  mem addr: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_size  out  2  00 byte, 01 half, 10 word
- mem_unsigned  out  1  zero-extend load (LBU/LHU)
- ir_write  out  1  latch IR
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  writeback from MDR
- reg_write  out  1  register file write
- alu_src_a  out  2  00 PC, 01 A, 10 shamt
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ext_zero  out  1  zero-extend imm (ANDI/ORI/XORI)
- pc_src  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 A
- alu_ctrl  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI
- state  out  4  current state, for debug
- illegal  out  1  one-cycle pulse on an undefined opcode/funct

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state = FETCH(0). All outputs are Moore outputs of state; the only exception is pc_en, which also depends on zero/neg in BRANCH. While rst = 1, every enable and strobe is forced to 0.
- Default for any output not listed in a state: 0.
- FETCH(0): mem_read, ir_write, src_a = 00, src_b = 01, ADD, pc_src = 00, pc_en = 1. Next: DECODE.
- DECODE(1): src_a = 00, src_b = 11, ADD (precompute branch target).
  - Loads/stores -> MEMADR.
  - op = 0, funct = JR -> JREG; other legal funct -> EXEC.
  - BEQ/BNE/BLEZ/BGTZ -> BRANCH.
  - ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI -> IEXEC.
  - J -> JUMP.
  - Anything else: illegal = 1 and -> FETCH.
- MEMADR(2): src_a = 01, src_b = 10, ADD. Loads -> MEMRD; SB/SH/SW -> MEMWR.
- MEMRD(3): iord = 1, mem_read = 1. Next: MEMWB.
- MEMWB(4): mem_to_reg = 1, reg_write = 1, reg_dst = 0. Next: FETCH.
- MEMWR(5): iord = 1, mem_write = 1. Next: FETCH.
- Memory size and sign: mem_size and mem_unsigned are valid in states 3–5 and come from op[1:0]/op[2]. LW and SW give 10.
- EXEC(6): src_a = 10 for SLL/SRL/SRA, else 01; src_b = 00; alu_ctrl from funct. ADD and ADDU both use ADD; SUB and SUBU both use SUB. SLLV/SRLV/SRAV use src_a = 01 and the shift code. Next: ALUWB.
- ALUWB(7): reg_dst = 1, reg_write = 1. Next: FETCH.
- BRANCH(8): src_a = 01, src_b = 00, SUB, pc_src = 01, branch = 1. cond by opcode:
  - BEQ: zero
  - BNE: !zero
  - BLEZ: zero | neg
  - BGTZ: !zero & !neg
  - Next: FETCH.
- IEXEC(9): src_a = 01, src_b = 10, ext_zero for ANDI/ORI/XORI, alu_ctrl from opcode (LUI -> 11). Next: IWB.
- IWB(10): reg_dst = 0, reg_write = 1, ext_zero held. Next: FETCH.
- JUMP(11): pc_src = 10, pc_en = 1. Next: FETCH.
- JREG(12): pc_src = 11, pc_en = 1. Next: FETCH.
- Codes 13–15 are unreachable; if entered, go to FETCH.
- Cycle counts: R-type 4, I-type ALU 4, load 5, store 4, branch 3, J/JR 3.
- Reset asserted in any state: next edge -> FETCH, and any in-flight write enable is dropped in that same cycle.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined: FETCH, MEMRD and MEMWR hold their state and outputs until mem_ready = 1.
  - ir_write and pc_en in FETCH assert only in the cycle where mem_ready = 1.
  - mem_write stays asserted until mem_ready = 1.
- Undefined: mem_ready is ignored; every memory access takes one cycle.

Test Plan:
- rst = 1 for 2 edges, then 0 -> state = 0, pc_en = 1 and ir_write = 1 in the first cycle; all writes 0 during reset.
- op = 0, funct = 100000 (ADD) -> states 0, 1, 6, 7, 0; in ALUWB reg_dst = 1, reg_write = 1; alu_ctrl = 0 in EXEC.
- op = LB -> states 0, 1, 2, 3, 4; mem_size = 00, mem_unsigned = 0; reg_write only in state 4. op = SH -> state 5 with mem_write = 1, mem_size = 01.
- BEQ with zero = 1 -> pc_en = 1 in state 8. BEQ with zero = 0 -> pc_en = 0. BLEZ with neg = 1 -> pc_en = 1. BGTZ with zero = 1 -> pc_en = 0.
- op = 6'b111111 -> illegal pulses for 1 cycle in DECODE, then FETCH; no reg_write or mem_write asserted.
- With MEM_WAIT_EN, SW and mem_ready held low 3 cycles -> stays in MEMWR with mem_write = 1 for 4 cycles, then FETCH.
